// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory responder: I/O register map,
// STATUS bit layout and the address-region decode enum.
package dmem_pkg;

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CYCLE  = 2'd2;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 4;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_IO,
        REG_MISS
    } region_e;

    // STATUS has a 4-bit count field; deeper FIFOs report 15 when fuller than that.
    function automatic logic [3:0] sat_nibble(input logic [31:0] v);
        return (v > 32'd15) ? 4'hF : v[3:0];
    endfunction

endpackage

// File: rtl/dmem_responder_sync_fifo.sv
// Synchronous FIFO with qualified push/pop: a pop on empty is ignored, and a push
// on full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == FULL_CNT);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        dout  = empty ? '0 : mem_q[rd_ptr_q];
        count = count_q;
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// CPU data-port responder: byte-lane-writable word RAM plus a 16-byte I/O window
// holding a console TX FIFO, a STATUS register and a free-running cycle counter.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] IO_BASE     = 32'h8000_0000,
    parameter int          FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dwe,
    output logic [31:0] drdata,
    output logic        con_valid,
    output logic [7:0]  con_data,
    input  logic        con_ready,
    output logic        bus_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    region_e          region;
    logic [AW-1:0]    word_idx;
    logic [1:0]       io_off;
    logic [31:0]      mem_q [DEPTH_WORDS];
    logic [31:0]      cycle_q, cycle_d;
    logic             ovf_q, ovf_d;
    logic             bus_err_q, bus_err_d;
    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic [7:0]       fifo_dout;
    logic [31:0]      status;

    always_comb begin
        word_idx = daddr[AW+1:2];
        io_off   = daddr[3:2];
        if ((daddr >> (AW + 2)) == 32'd0) begin
            region = REG_RAM;
        end else if (daddr[31:4] == IO_BASE[31:4]) begin
            region = REG_IO;
        end else begin
            region = REG_MISS;
        end
    end

    // Pushes during reset are suppressed so a coincident TXDATA store is dropped.
    always_comb begin
        fifo_push = (region == REG_IO) && (io_off == OFF_TXDATA) && dwe[0] && !reset;
        fifo_pop  = !fifo_empty && con_ready;
        con_valid = !fifo_empty;
        con_data  = fifo_dout;
        bus_err   = bus_err_q;
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (dwdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        status                      = '0;
        status[ST_FULL]             = fifo_full;
        status[ST_EMPTY]            = fifo_empty;
        status[ST_OVF]              = ovf_q;
        status[ST_CNT_LSB +: 4]     = sat_nibble(32'(fifo_count));

        drdata = '0;
        case (region)
            REG_RAM: drdata = mem_q[word_idx];
            REG_IO: begin
                case (io_off)
                    OFF_STATUS: drdata = status;
                    OFF_CYCLE:  drdata = cycle_q;
                    default:    drdata = '0;
                endcase
            end
            default: drdata = '0;
        endcase
    end

    always_comb begin
        ovf_d = ovf_q;
        if ((region == REG_IO) && (io_off == OFF_STATUS) && dwe[0] && dwdata[ST_OVF]) begin
            ovf_d = 1'b0;
        end
        if (fifo_push && fifo_full && !fifo_pop) begin
            ovf_d = 1'b1;
        end

        cycle_d = cycle_q + 32'd1;
        if ((region == REG_IO) && (io_off == OFF_CYCLE) && (dwe != 4'b0000)) begin
            cycle_d = '0;
        end

        bus_err_d = bus_err_q || ((region == REG_MISS) && (dwe != 4'b0000));
    end

    // RAM contents survive reset and a store coincident with reset still lands.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if ((region == REG_RAM) && dwe[i]) begin
                mem_q[word_idx][8*i +: 8] <= dwdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q   <= '0;
            ovf_q     <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            cycle_q   <= cycle_d;
            ovf_q     <= ovf_d;
            bus_err_q <= bus_err_d;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios then random traffic, checked by a
// negedge monitor against a queue/array reference model of the memory map.
module tb_dmem_responder;

    localparam int          DEPTH_WORDS = 1024;
    localparam logic [31:0] IO_BASE     = 32'h8000_0000;
    localparam int          FIFO_DEPTH  = 8;

    logic        clk;
    logic        reset;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dwe;
    logic [31:0] drdata;
    logic        con_valid;
    logic [7:0]  con_data;
    logic        con_ready;
    logic        bus_err;

    dmem_responder #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IO_BASE     (IO_BASE),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .daddr     (daddr),
        .dwdata    (dwdata),
        .dwe       (dwe),
        .drdata    (drdata),
        .con_valid (con_valid),
        .con_data  (con_data),
        .con_ready (con_ready),
        .bus_err   (bus_err)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];
    logic [7:0]  con_exp_q[$];
    logic        rd_chk = 1'b0;
    logic        mon_en = 1'b0;
    logic [31:0] mon_last = '0;

    // ---------------- reference model ----------------
    logic [31:0] ram_m [int];
    logic [7:0]  fifo_m[$];
    logic        ovf_m = 1'b0;
    logic        bus_err_m = 1'b0;
    logic [31:0] cycle_m = '0;

    // 0 = RAM, 1 = I/O window, 2 = miss
    function automatic int region_of(input logic [31:0] a);
        if (a < 32'(DEPTH_WORDS * 4)) return 0;
        if (a >= IO_BASE && a < IO_BASE + 32'd16) return 1;
        return 2;
    endfunction

    function automatic logic [31:0] model_status();
        int cnt;
        logic [31:0] s;
        cnt = fifo_m.size();
        if (cnt > 15) cnt = 15;
        s = 32'(cnt) * 16;
        if (ovf_m) s = s + 4;
        if (fifo_m.size() == 0) s = s + 2;
        if (fifo_m.size() == FIFO_DEPTH) s = s + 1;
        return s;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int off;
        case (region_of(a))
            0: return ram_m.exists(int'(a / 4)) ? ram_m[int'(a / 4)] : 32'h0;
            1: begin
                off = int'((a - IO_BASE) / 4);
                if (off == 1) return model_status();
                if (off == 2) return cycle_m;
                return 32'h0;
            end
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_edge();
        int          off;
        logic [31:0] w;
        bit          pop;
        if (region_of(daddr) == 0 && dwe != 4'b0000) begin
            w = ram_m.exists(int'(daddr / 4)) ? ram_m[int'(daddr / 4)] : 32'h0;
            for (int i = 0; i < 4; i++)
                if (dwe[i]) w[8*i +: 8] = dwdata[8*i +: 8];
            ram_m[int'(daddr / 4)] = w;
        end
        if (reset) begin
            fifo_m.delete();
            con_exp_q.delete();
            ovf_m     = 1'b0;
            cycle_m   = '0;
            bus_err_m = 1'b0;
            return;
        end
        off = int'((daddr - IO_BASE) / 4);
        pop = (fifo_m.size() > 0) && con_ready;
        if (pop) void'(fifo_m.pop_front());
        if (region_of(daddr) == 1 && off == 0 && dwe[0]) begin
            if (fifo_m.size() < FIFO_DEPTH) begin
                fifo_m.push_back(dwdata[7:0]);
                con_exp_q.push_back(dwdata[7:0]);
            end else begin
                ovf_m = 1'b1;
            end
        end
        if (region_of(daddr) == 1 && off == 1 && dwe[0] && dwdata[2]) ovf_m = 1'b0;
        if (region_of(daddr) == 1 && off == 2 && dwe != 4'b0000) cycle_m = '0;
        else cycle_m = cycle_m + 32'd1;
        if (region_of(daddr) == 2 && dwe != 4'b0000) bus_err_m = 1'b1;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares whatever the DUT presents mid-cycle against the model.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rd_chk) begin
                if (exp_q.size() == 0) begin
                    check("rd_queue_underflow", 32'd1, 32'd0);
                end else begin
                    check(name_q.pop_front(), drdata, exp_q.pop_front());
                    mon_last = drdata;
                end
            end
            check("con_valid", {31'b0, con_valid}, {31'b0, con_exp_q.size() != 0});
            if (con_valid && con_exp_q.size() != 0) begin
                check("con_data", {24'b0, con_data}, {24'b0, con_exp_q[0]});
                if (con_ready) void'(con_exp_q.pop_front());
            end
            check("bus_err", {31'b0, bus_err}, {31'b0, bus_err_m});
        end
    end

    // ---------------- driver ----------------
    task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we,
                        input bit chk = 1'b0, input string nm = "rd",
                        input bit use_c = 1'b0, input logic [31:0] cval = 32'h0);
        daddr  = a;
        dwdata = wd;
        dwe    = we;
        if (chk) begin
            exp_q.push_back(use_c ? cval : model_read(a));
            name_q.push_back(nm);
        end
        rd_chk = chk;
        @(posedge clk);
        model_edge();
        #1;
        rd_chk = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(32'h0000_0200, 32'h0, 4'b0000);
    endtask

    logic [31:0] c0, c1;
    logic [31:0] ra;
    int          op;

    initial begin
        reset = 1'b1; daddr = '0; dwdata = '0; dwe = '0; con_ready = 1'b0;
        @(posedge clk);
        #1;
        idle(2);
        reset  = 1'b0;
        mon_en = 1'b1;
        step(IO_BASE + 4, 0, 0, 1, "status_reset", 1, 32'h2);
        check("bus_err_reset", {31'b0, bus_err}, 32'h0);

        // Byte-lane merge and read-during-write
        step(32'h10, 32'hDEAD_BEEF, 4'b1111);
        step(32'h10, 32'h0000_5500, 4'b0010);
        step(32'h10, 0, 0, 1, "ram_merge", 1, 32'hDEAD_55EF);
        step(32'h10, 32'h1234_5678, 4'b1111, 1, "rdw_old", 1, 32'hDEAD_55EF);
        step(32'h13, 0, 0, 1, "rdw_new", 1, 32'h1234_5678);

        // Overflow with stalled sink, then drain
        con_ready = 1'b0;
        for (int i = 0; i < 9; i++) step(IO_BASE, 32'h41 + 32'(i), 4'b0001);
        step(IO_BASE + 4, 0, 0, 1, "status_full_ovf", 1, 32'h85);
        con_ready = 1'b1;
        idle(10);
        step(IO_BASE + 4, 0, 0, 1, "status_drained", 1, 32'h06);
        step(IO_BASE + 4, 32'h4, 4'b0001);
        step(IO_BASE + 4, 0, 0, 1, "status_ovf_clr", 1, 32'h02);
        step(IO_BASE, 0, 0, 1, "txdata_reads0", 1, 32'h0);

        // Push into a full FIFO while it pops
        con_ready = 1'b0;
        for (int i = 0; i < 8; i++) step(IO_BASE, 32'h61 + 32'(i), 4'b0001);
        step(IO_BASE + 4, 0, 0, 1, "status_full", 1, 32'h81);
        con_ready = 1'b1;
        step(IO_BASE, 32'h5A, 4'b0001);
        step(IO_BASE + 4, 0, 0, 1, "status_push_pop", 1, 32'h81);
        idle(10);
        step(IO_BASE + 4, 0, 0, 1, "status_empty2", 1, 32'h02);

        // Cycle counter
        step(IO_BASE + 8, 0, 0, 1, "cycle_a");
        c0 = mon_last;
        idle(9);
        step(IO_BASE + 8, 0, 0, 1, "cycle_b");
        c1 = mon_last;
        check("cycle_diff", c1 - c0, 32'd10);
        step(IO_BASE + 8, 32'hFFFF_FFFF, 4'b0100);
        step(IO_BASE + 8, 0, 0, 1, "cycle_clr0", 1, 32'd0);
        step(IO_BASE + 8, 0, 0, 1, "cycle_after_clr", 1, 32'd1);
        step(IO_BASE + 12, 32'hFFFF_FFFF, 4'b1111);
        step(IO_BASE + 12, 0, 0, 1, "io_off3", 1, 32'h0);

        // Misses: loads are silent, stores set sticky bus_err
        step(32'h0, 32'hCAFE_F00D, 4'b1111);
        step(32'h4000_0004, 0, 0, 1, "miss_load", 1, 32'h0);
        check("bus_err_load", {31'b0, bus_err}, 32'h0);
        step(32'h4000_0000, 32'hFF, 4'b0001);
        check("bus_err_set", {31'b0, bus_err}, 32'h1);
        step(32'h0, 0, 0, 1, "miss_no_alias", 1, 32'hCAFE_F00D);
        step(32'h4000_0000, 0, 0, 1, "miss_read", 1, 32'h0);

        // Reset mid-operation: FIFO discarded, RAM store applied, I/O store dropped
        con_ready = 1'b0;
        for (int i = 0; i < 3; i++) step(IO_BASE, 32'h70 + 32'(i), 4'b0001);
        reset = 1'b1;
        step(32'h20, 32'hA5A5_A5A5, 4'b1111);
        step(IO_BASE, 32'h77, 4'b0001);
        reset = 1'b0;
        check("bus_err_cleared", {31'b0, bus_err}, 32'h0);
        step(32'h20, 0, 0, 1, "ram_write_in_reset", 1, 32'hA5A5_A5A5);
        step(IO_BASE + 4, 0, 0, 1, "status_after_reset", 1, 32'h02);
        step(IO_BASE + 8, 0, 0, 1, "cycle_after_reset");

        // Random traffic
        for (int k = 0; k < 16; k++) step(32'h100 + 32'(4 * k), $urandom, 4'b1111);
        for (int n = 0; n < 400; n++) begin
            con_ready = ($urandom_range(0, 1) == 1);
            ra = 32'h100 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2: step(ra, $urandom, 4'($urandom_range(0, 15)));
                3, 4:    step(ra, 0, 0, 1, "rand_ram");
                5, 6:    step(IO_BASE, $urandom, 4'($urandom_range(0, 15)));
                7:       step(IO_BASE + 4, 0, 0, 1, "rand_status");
                8:       step(IO_BASE + 8, 0, 0, 1, "rand_cycle");
                default: begin
                    if ($urandom_range(0, 1) == 1) step(IO_BASE + 4, $urandom, 4'b0001);
                    else step(32'h9000_0000 + 32'($urandom_range(0, 255)), 0, 0, 1, "rand_miss");
                end
            endcase
        end
        con_ready = 1'b1;
        idle(12);
        step(IO_BASE + 4, 0, 0, 1, "final_status");
        check("rd_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
